// File: rtl/sync_debounce_edge.sv
// Multi-channel input conditioner: per-channel metastability chain, debounce
// filter and registered rise/fall edge pulses in the sysclk domain.
module sync_debounce_edge #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      STAGES          = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    input  logic             tick_en,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_debounce_edge: STAGES must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("sync_debounce_edge: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] level_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    assign sync_out = sync_q[STAGES-1];

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_q[i] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= async_in;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // A stalled tick holds the count; only agreement with level_out clears it.
    always_comb begin
        level_nxt = level_out;
        rise_nxt  = '0;
        fall_nxt  = '0;
        cnt_nxt   = cnt;
        for (int unsigned c = 0; c < WIDTH; c++) begin
            if (sync_out[c] == level_out[c]) begin
                cnt_nxt[c] = '0;
            end else if (tick_en) begin
                if (cnt[c] == CNT_MAX) begin
                    level_nxt[c] = sync_out[c];
                    cnt_nxt[c]   = '0;
                    rise_nxt[c]  = sync_out[c];
                    fall_nxt[c]  = ~sync_out[c];
                end else begin
                    cnt_nxt[c] = cnt[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            level_out  <= RESET_VAL;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
            for (int unsigned c = 0; c < WIDTH; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            level_out  <= level_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            any_change <= |(rise_nxt | fall_nxt);
            cnt        <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: vector tables, hand sequences for the
// multi-cycle corners, and randomized traffic against a reference model.
module tb_sync_debounce_edge;

    localparam int STG = 2;
    localparam int DC  = 4;

    logic       sysclk = 1'b0;
    logic       reset_n;
    logic [3:0] async_in;
    logic       tick_en;
    logic [3:0] sync_out, level_out, rise_pulse, fall_pulse;
    logic       any_change;

    logic [3:0] async6;
    logic [3:0] sync6, level6, rise6, fall6;
    logic       any6;

    int checks   = 0;
    int failures = 0;

    always #5 sysclk = ~sysclk;

    sync_debounce_edge #(
        .WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'h0)
    ) dut (
        .sysclk(sysclk), .reset_n(reset_n), .async_in(async_in), .tick_en(tick_en),
        .sync_out(sync_out), .level_out(level_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .any_change(any_change)
    );

    sync_debounce_edge #(
        .WIDTH(4), .STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_VAL(4'hF)
    ) dut6 (
        .sysclk(sysclk), .reset_n(reset_n), .async_in(async6), .tick_en(tick_en),
        .sync_out(sync6), .level_out(level6), .rise_pulse(rise6),
        .fall_pulse(fall6), .any_change(any6)
    );

    // Reference model: a delay line of sampled inputs plus a per-channel
    // count of consecutive qualified ticks spent disagreeing with the level.
    logic [3:0] m_q[$];
    logic [3:0] m_level, m_rise, m_fall;
    logic       m_any;
    int         m_run[4];

    task automatic model_reset();
        m_q = {};
        for (int i = 0; i < STG; i++) m_q.push_back(4'h0);
        m_level = 4'h0;
        m_rise  = 4'h0;
        m_fall  = 4'h0;
        m_any   = 1'b0;
        for (int c = 0; c < 4; c++) m_run[c] = 0;
    endtask

    task automatic model_edge(input logic [3:0] in, input logic tk);
        logic [3:0] s;
        logic [3:0] old_level;
        s = m_q[$];
        old_level = m_level;
        for (int c = 0; c < 4; c++) begin
            if (s[c] != old_level[c]) begin
                if (tk) m_run[c] = m_run[c] + 1;
                if (m_run[c] == DC) begin
                    m_level[c] = s[c];
                    m_run[c]   = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_rise = m_level & ~old_level;
        m_fall = ~m_level & old_level;
        m_any  = (m_rise != 4'h0) || (m_fall != 4'h0);
        m_q.push_front(in);
        void'(m_q.pop_back());
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        if (reset_n) model_edge(async_in, tick_en);
        @(negedge sysclk);
        check("model", {15'd0, sync_out, level_out, rise_pulse, fall_pulse, any_change},
              {15'd0, m_q[$], m_level, m_rise, m_fall, m_any});
    endtask

    typedef struct {
        logic [3:0] in;
        logic       tk;
        logic [3:0] sync;
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    vec_t tbl[16];

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            async_in = tbl[i].in;
            tick_en  = tbl[i].tk;
            tick();
            check($sformatf("tbl[%0d]", i),
                  {15'd0, sync_out, level_out, rise_pulse, fall_pulse, any_change},
                  {15'd0, tbl[i].sync, tbl[i].level, tbl[i].rise, tbl[i].fall, tbl[i].any});
        end
    endtask

    initial begin
        int edge_at;
        int hits;
        logic saw;
        int hold;
        logic [3:0] rv;

        // Clean step on channel 0: level and rise at edge 6 only.
        tbl[0]  = '{4'h1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{4'h1, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[2]  = '{4'h1, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[3]  = '{4'h1, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[4]  = '{4'h1, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[5]  = '{4'h1, 1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1};
        tbl[6]  = '{4'h1, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[7]  = '{4'h1, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
        // Simultaneous channels: 1010 -> 0101.
        tbl[8]  = '{4'h5, 1'b1, 4'hA, 4'hA, 4'h0, 4'h0, 1'b0};
        tbl[9]  = '{4'h5, 1'b1, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0};
        tbl[10] = '{4'h5, 1'b1, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0};
        tbl[11] = '{4'h5, 1'b1, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0};
        tbl[12] = '{4'h5, 1'b1, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0};
        tbl[13] = '{4'h5, 1'b1, 4'h5, 4'h5, 4'h5, 4'hA, 1'b1};
        tbl[14] = '{4'h5, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 1'b0};
        tbl[15] = '{4'h5, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 1'b0};

        reset_n  = 1'b0;
        async_in = 4'h0;
        tick_en  = 1'b1;
        async6   = 4'hF;
        model_reset();
        repeat (2) @(negedge sysclk);
        check("rst_a", {15'd0, sync_out, level_out, rise_pulse, fall_pulse, any_change}, 32'd0);
        check("rst6_level", {28'd0, level6}, 32'hF);
        check("rst6_sync", {28'd0, sync6}, 32'hF);
        check("rst6_pulses", {23'd0, rise6, fall6, any6}, 32'd0);
        reset_n = 1'b1;

        run_rows(0, 7);

        // Glitches on channel 1 shorter than the filter; the second burst
        // would fire if the first left its count behind.
        saw = 1'b0;
        for (int g = 0; g < 2; g++) begin
            async_in = 4'h3;
            repeat (3) begin tick(); saw |= rise_pulse[1]; end
            async_in = 4'h1;
            repeat (4) begin tick(); saw |= rise_pulse[1]; end
        end
        check("glitch_rise", {31'd0, saw}, 32'd0);
        check("glitch_level", {31'd0, level_out[1]}, 32'd0);

        // Prescaled fall on channel 2: ticks at edges 4, 8, 12, 16.
        async_in = 4'h5;
        repeat (8) tick();
        check("pre_level_set", {31'd0, level_out[2]}, 32'd1);
        async_in = 4'h1;
        edge_at = -1;
        hits = 0;
        for (int k = 0; k < 20; k++) begin
            tick_en = (k % 4 == 3);
            tick();
            if (fall_pulse[2]) begin edge_at = k + 1; hits++; end
        end
        tick_en = 1'b1;
        check("pre_fall_edge", edge_at, 32'd16);
        check("pre_fall_count", hits, 32'd1);
        check("pre_level", {31'd0, level_out[2]}, 32'd0);

        async_in = 4'hA;
        repeat (10) tick();
        run_rows(8, 15);

        // Reset mid-count: outputs clear without a clock edge.
        async_in = 4'hF;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_async", {15'd0, sync_out, level_out, rise_pulse, fall_pulse, any_change}, 32'd0);
        check("midrst6_level", {28'd0, level6}, 32'hF);
        repeat (2) tick();
        reset_n = 1'b1;
        edge_at = -1;
        hits = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rise_pulse == 4'hF) begin edge_at = k + 1; hits++; end
        end
        check("rel_rise_edge", edge_at, 32'd6);
        check("rel_rise_count", hits, 32'd1);
        check("rel_level", {28'd0, level_out}, 32'hF);

        for (int n = 0; n < 60; n++) begin
            rv = 4'($urandom);
            async_in = rv;
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                tick_en = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        tick_en = 1'b1;

        // Corner instance: STAGES=3, DEBOUNCE_CYCLES=1, reset to all ones.
        async6 = 4'h0;
        edge_at = -1;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (fall6 == 4'hF) begin edge_at = k + 1; hits++; end
        end
        check("c6_fall_edge", edge_at, 32'd4);
        check("c6_fall_count", hits, 32'd1);
        check("c6_level", {28'd0, level6}, 32'h0);
        check("c6_rise", {28'd0, rise6}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
